// File: rtl/stdcell_test_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stdcell_test_sequencer: Wishbone-programmed parallel truth-table grader for a
// row of cells-under-test. Optional CUT_SYNC_EN adds a 2-flop cut_out sync.
// Revision: 1.0
// ---------------------------------------------------------------------------
module stdcell_test_sequencer #(
  parameter int          NUM_CH   = 19,
  parameter int          MAX_IN   = 4,
  parameter int          CNT_W    = 16,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [31:0]                wbs_dat_i,
  input  logic [31:0]                wbs_adr_i,
  output logic                       wbs_ack_o,
  output logic [31:0]                wbs_dat_o,
  output logic [NUM_CH*MAX_IN-1:0]   cut_in,
  input  logic [NUM_CH-1:0]          cut_out,
  output logic                       busy_o
);

  localparam int NPAT = 1 << MAX_IN;
  localparam int PC_W = $clog2(NUM_CH + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [8:0]              cnt_q;
  logic [MAX_IN-1:0]       pat_q;
  logic [7:0]              loop_q;
  logic [7:0]              settle_q, loops_q;
  logic [NPAT-1:0]         tt_q [NUM_CH];
  logic [CNT_W-1:0]        errcnt_q;
  logic [NUM_CH-1:0]       failmask_q;
  logic                    done_q, pass_q, aborted_q;
  logic                    start_q, abort_q;
  logic                    ack_q;
  logic [31:0]             dat_q;
  logic [NUM_CH*MAX_IN-1:0] cut_in_q;

  logic [NUM_CH-1:0]       cut_cmp;
  logic [8:0]              sync_xtra;

`ifdef CUT_SYNC_EN
  logic [NUM_CH-1:0] sync1_q, sync2_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= cut_out;
      sync2_q <= sync1_q;
    end
  end

  assign cut_cmp   = sync2_q;
  assign sync_xtra = 9'd2;
`else
  assign cut_cmp   = cut_out;
  assign sync_xtra = 9'd0;
`endif

  // Bus decode
  logic       req, hit, wr, busy, tt_hit;
  logic [5:0] word, tt_idx;
  logic [31:0] wmask, rdata;
  logic       unused_ok;

  assign req    = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign hit    = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign wr     = req & wbs_we_i & hit;
  assign word   = wbs_adr_i[7:2];
  assign tt_idx = word - 6'd16;
  assign tt_hit = (word[5:4] != 2'b00) && (tt_idx < 6'(NUM_CH));
  assign busy   = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign unused_ok = ^{wbs_dat_i, wbs_sel_i, wbs_adr_i[1:0]};

  always_comb begin
    wmask = '0;
    for (int i = 0; i < 4; i++) begin
      wmask[i*8 +: 8] = {8{wbs_sel_i[i]}};
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (word)
        6'h01:   rdata[3:0] = {aborted_q, pass_q, done_q, busy};
        6'h02:   rdata[CNT_W-1:0] = errcnt_q;
        6'h03:   rdata[NUM_CH-1:0] = failmask_q;
        6'h04:   rdata[7:0] = settle_q;
        6'h05:   rdata[7:0] = loops_q;
        default: begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (tt_hit && (tt_idx == 6'(c))) rdata[NPAT-1:0] = tt_q[c];
          end
        end
      endcase
    end
  end

  // Compare datapath
  logic [NUM_CH-1:0]      mis;
  logic [PC_W-1:0]        mis_cnt;
  logic [CNT_W+PC_W-1:0]  err_sum;
  logic [CNT_W-1:0]       err_next;
  logic [7:0]             settle_eff, loops_eff;
  logic                   last_pat, more_loops;

  always_comb begin
    mis     = '0;
    mis_cnt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      mis[c]  = cut_cmp[c] ^ tt_q[c][pat_q];
      mis_cnt = mis_cnt + PC_W'(mis[c]);
    end
    err_sum  = (CNT_W+PC_W)'(errcnt_q) + (CNT_W+PC_W)'(mis_cnt);
    err_next = (err_sum[CNT_W+PC_W-1:CNT_W] != '0) ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
  end

  assign settle_eff = (settle_q == 8'd0) ? 8'd1 : settle_q;
  assign loops_eff  = (loops_q == 8'd0) ? 8'd1 : loops_q;
  assign last_pat   = &pat_q;
  assign more_loops = ({1'b0, loop_q} + 9'd1) < {1'b0, loops_eff};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_q && !abort_q) state_d = S_APPLY;
      S_APPLY:  state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == 9'd0) state_d = S_SAMPLE;
      S_SAMPLE: state_d = (last_pat && !more_loops) ? S_DONE : S_APPLY;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (busy && abort_q) state_d = S_IDLE;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pat_q      <= '0;
      loop_q     <= '0;
      settle_q   <= 8'd4;
      loops_q    <= 8'd1;
      for (int c = 0; c < NUM_CH; c++) tt_q[c] <= '0;
      errcnt_q   <= '0;
      failmask_q <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      aborted_q  <= 1'b0;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      cut_in_q   <= '0;
    end else begin
      ack_q   <= req;
      dat_q   <= (req && !wbs_we_i) ? rdata : 32'd0;
      start_q <= wr && (word == 6'h00) && wbs_sel_i[0] && wbs_dat_i[0];
      abort_q <= wr && (word == 6'h00) && wbs_sel_i[0] && wbs_dat_i[1];

      // Configuration is frozen for the duration of a run
      if (wr && !busy) begin
        if (word == 6'h04 && wbs_sel_i[0]) settle_q <= wbs_dat_i[7:0];
        if (word == 6'h05 && wbs_sel_i[0]) loops_q  <= wbs_dat_i[7:0];
        for (int c = 0; c < NUM_CH; c++) begin
          if (tt_hit && (tt_idx == 6'(c))) begin
            tt_q[c] <= (tt_q[c] & ~wmask[NPAT-1:0]) | (wbs_dat_i[NPAT-1:0] & wmask[NPAT-1:0]);
          end
        end
      end

      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (state_d == S_APPLY) begin
            errcnt_q   <= '0;
            failmask_q <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            aborted_q  <= 1'b0;
            pat_q      <= '0;
            loop_q     <= '0;
          end
        end
        S_APPLY: begin
          cut_in_q <= {NUM_CH{pat_q}};
          cnt_q    <= {1'b0, settle_eff} - 9'd1 + sync_xtra;
        end
        S_SETTLE: begin
          if (cnt_q != 9'd0) cnt_q <= cnt_q - 9'd1;
        end
        S_SAMPLE: begin
          failmask_q <= failmask_q | mis;
          errcnt_q   <= err_next;
          if (!last_pat) begin
            pat_q <= pat_q + 1'b1;
          end else if (more_loops) begin
            pat_q  <= '0;
            loop_q <= loop_q + 8'd1;
          end
        end
        default: ;
      endcase

      if (state_d == S_DONE) begin
        done_q   <= 1'b1;
        pass_q   <= ~|(failmask_q | mis);
        cut_in_q <= '0;
      end

      if (busy && abort_q) begin
        aborted_q <= 1'b1;
        done_q    <= 1'b1;
        pass_q    <= 1'b0;
        cut_in_q  <= '0;
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign cut_in    = cut_in_q;
  assign busy_o    = busy;

endmodule
`default_nettype wire

// File: tb/tb_stdcell_test_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for stdcell_test_sequencer: loopback cell models, reference grading model.
module tb_stdcell_test_sequencer;

  localparam int NUM_CH = 19;
  localparam int MAX_IN = 4;
  localparam int CNT_W  = 16;
  localparam int NPAT   = 16;
  localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef CUT_SYNC_EN
  localparam int XTRA = 2;
`else
  localparam int XTRA = 0;
`endif
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_STAT = BASE + 32'h04;
  localparam logic [31:0] A_ERR  = BASE + 32'h08;
  localparam logic [31:0] A_FM   = BASE + 32'h0C;
  localparam logic [31:0] A_SET  = BASE + 32'h10;
  localparam logic [31:0] A_LOOP = BASE + 32'h14;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]               wbs_sel_i;
  logic [31:0]              wbs_dat_i, wbs_adr_i;
  logic                     wbs_ack_o;
  logic [31:0]              wbs_dat_o;
  logic [NUM_CH*MAX_IN-1:0] cut_in;
  logic [NUM_CH-1:0]        cut_out;
  logic                     busy_o;

  int checks = 0;
  int errors = 0;
  logic [15:0] cell_tt [NUM_CH];
  logic [15:0] tt_m [NUM_CH];
  int settle_m, loops_m;
  longint busy_total = 0;

  stdcell_test_sequencer #(
    .NUM_CH(NUM_CH), .MAX_IN(MAX_IN), .CNT_W(CNT_W), .BASE_ADR(BASE)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .cut_in(cut_in), .cut_out(cut_out), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (busy_o) busy_total <= busy_total + 1;

  // Each cell behaves as the function held in cell_tt, addressed by its inputs
  always_comb begin
    cut_out = '0;
    for (int c = 0; c < NUM_CH; c++) cut_out[c] = cell_tt[c][cut_in[c*MAX_IN +: MAX_IN]];
  end

  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                         input logic [3:0] sel, output logic [31:0] rdat);
    int lat;
    lat  = 0;
    rdat = '0;
    @(posedge clk); #1;
    wbs_adr_i = adr; wbs_we_i = we; wbs_dat_i = wdat; wbs_sel_i = sel;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    for (int i = 1; i <= 4 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin lat = i; rdat = wbs_dat_o; end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL wb_ack adr=%08h latency=%0d required=1", adr, lat);
    end
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel = 4'hF);
    logic [31:0] dummy;
    wb_xfer(adr, 1'b1, d, sel, dummy);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] d);
    wb_xfer(adr, 1'b0, 32'h0, 4'hF, d);
  endtask

  task automatic program_all(input int s, input int l);
    settle_m = s;
    loops_m  = l;
    wb_write(A_SET, 32'(s));
    wb_write(A_LOOP, 32'(l));
    for (int c = 0; c < NUM_CH; c++) wb_write(BASE + 32'h40 + 32'(4*c), {16'h0, tt_m[c]});
  endtask

  task automatic calc_expect(output logic [15:0] e_err, output logic [NUM_CH-1:0] e_fm,
                             output int e_cyc);
    int L, S, m;
    longint tot;
    L = (loops_m == 0) ? 1 : loops_m;
    S = (settle_m == 0) ? 1 : settle_m;
    tot = 0;
    e_fm = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      m = $countones(cell_tt[c] ^ tt_m[c]);
      tot += longint'(L) * m;
      e_fm[c] = (m != 0);
    end
    e_err = (tot > 65535) ? 16'hFFFF : 16'(tot);
    e_cyc = NPAT * L * (2 + XTRA + S);
  endtask

  task automatic wait_done_and_check(input longint b0, input string name);
    logic [15:0] e_err;
    logic [NUM_CH-1:0] e_fm;
    int e_cyc;
    bit seen, fin;
    logic [31:0] d;
    calc_expect(e_err, e_fm, e_cyc);
    seen = 0; fin = 0;
    for (int i = 0; i < 2*e_cyc + 100 && !fin; i++) begin
      @(posedge clk); #1;
      if (busy_o) seen = 1;
      else if (seen) fin = 1;
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL %s_timeout run did not complete, seen_busy=%0d", name, seen); end
    checks++;
    if (cut_in !== '0) begin errors++; $display("FAIL %s_cut_in_done got=%h required=0", name, cut_in); end
    checks++;
    if (busy_total - b0 != longint'(e_cyc)) begin
      errors++; $display("FAIL %s_cycles got=%0d required=%0d", name, busy_total - b0, e_cyc);
    end
    wb_read(A_STAT, d);
    checks++;
    if (d !== {28'h0, 1'b0, (e_fm == '0), 1'b1, 1'b0}) begin
      errors++; $display("FAIL %s_status got=%h required=%h", name, d, {28'h0, 1'b0, (e_fm == '0), 2'b10});
    end
    wb_read(A_ERR, d);
    checks++;
    if (d !== {16'h0, e_err}) begin errors++; $display("FAIL %s_errcnt got=%0d required=%0d", name, d, e_err); end
    wb_read(A_FM, d);
    checks++;
    if (d !== {13'h0, e_fm}) begin errors++; $display("FAIL %s_failmask got=%h required=%h", name, d, e_fm); end
  endtask

  task automatic run(input string name);
    longint b0;
    b0 = busy_total;
    wb_write(A_CTRL, 32'h1);
    wait_done_and_check(b0, name);
  endtask

  task automatic set_loopback_t1();
    for (int c = 0; c < NUM_CH; c++) begin cell_tt[c] = 16'h0; tt_m[c] = 16'h0; end
    cell_tt[0] = 16'h8888;   // AND of in[1:0]
    cell_tt[1] = 16'h6666;   // XOR of in[1:0]
    tt_m[0] = 16'h8888;
    tt_m[1] = 16'h6666;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++;
    if ({wbs_ack_o, wbs_dat_o, cut_in, busy_o} !== '0) begin
      errors++; $display("FAIL reset_outputs ack=%b dat=%h cut_in=%h busy=%b required all 0", wbs_ack_o, wbs_dat_o, cut_in, busy_o);
    end
    wb_read(A_CTRL, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got=%h required=0", d); end
    wb_read(A_STAT, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_status got=%h required=0", d); end
    wb_read(A_ERR, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_errcnt got=%h required=0", d); end
    wb_read(A_FM, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_failmask got=%h required=0", d); end
    wb_read(A_SET, d); checks++;
    if (d !== 32'd4) begin errors++; $display("FAIL reset_settle got=%h required=4", d); end
    wb_read(A_LOOP, d); checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL reset_loops got=%h required=1", d); end
    wb_read(BASE + 32'h40, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_tt0 got=%h required=0", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    wb_write(A_SET, 32'hA5);
    wb_write(A_SET, 32'hFF, 4'h0);
    wb_read(A_SET, d); checks++;
    if (d !== 32'hA5) begin errors++; $display("FAIL regs_settle got=%h required=a5", d); end
    wb_write(A_LOOP, 32'h1234_563C);
    wb_read(A_LOOP, d); checks++;
    if (d !== 32'h3C) begin errors++; $display("FAIL regs_loops got=%h required=3c", d); end
    wb_write(BASE + 32'h4C, 32'h1234);
    wb_write(BASE + 32'h4C, 32'hABCD, 4'b0001);
    wb_write(BASE + 32'h4C, 32'h5678, 4'b0010);
    wb_read(BASE + 32'h4C, d); checks++;
    if (d !== 32'h56CD) begin errors++; $display("FAIL regs_tt3_bytesel got=%h required=56cd", d); end
    wb_write(BASE + 32'h88, 32'hFFFF_BEEF);
    wb_read(BASE + 32'h88, d); checks++;
    if (d !== 32'hBEEF) begin errors++; $display("FAIL regs_tt18 got=%h required=beef", d); end
    wb_write(BASE + 32'h8C, 32'hFFFF_FFFF);
    wb_read(BASE + 32'h8C, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL regs_tt19 got=%h required=0", d); end
    wb_read(BASE + 32'hFC, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL regs_fc got=%h required=0", d); end
    wb_write(BASE + 32'h100, 32'hFFFF_FFFF);
    wb_read(BASE + 32'h100, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL regs_offbase got=%h required=0", d); end
    wb_read(BASE + 32'h20, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL regs_unmapped got=%h required=0", d); end
  endtask

  task automatic test_t1();
    set_loopback_t1();
    program_all(2, 1);
    run("t1");
  endtask

  task automatic test_t2();
    set_loopback_t1();
    tt_m[1] = 16'h6667;
    program_all(2, 1);
    run("t2");
  endtask

  task automatic test_t3();
    set_loopback_t1();
    cell_tt[0] = 16'h0;      // stuck-at-0
    tt_m[0]    = 16'hFFFF;
    program_all(2, 3);
    run("t3");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cell_tt[c] = 16'($urandom);
        tt_m[c] = cell_tt[c] ^ (($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0);
      end
      program_all(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      run("random");
    end
  endtask

  task automatic test_saturate();
    for (int c = 0; c < NUM_CH; c++) begin
      cell_tt[c] = 16'($urandom);
      tt_m[c] = ~cell_tt[c];
    end
    program_all(0, 255);
    run("saturate");
  endtask

  task automatic test_abort();
    longint b0, k;
    int period;
    logic [31:0] d;
    set_loopback_t1();
    cell_tt[0] = 16'h0;
    tt_m[0]    = 16'hFFFF;
    program_all(2, 1);
    period = 2 + XTRA + 2;
    b0 = busy_total;
    wb_write(A_CTRL, 32'h1);
    repeat (10) @(posedge clk);
    wb_write(A_CTRL, 32'h2);
    @(posedge clk); #1;
    k = busy_total - b0;
    checks++;
    if (busy_o !== 1'b0 || cut_in !== '0) begin
      errors++; $display("FAIL abort_idle busy=%b cut_in=%h required busy=0 cut_in=0", busy_o, cut_in);
    end
    wb_read(A_STAT, d); checks++;
    if (d !== 32'hA) begin errors++; $display("FAIL abort_status got=%h required=a", d); end
    wb_read(A_ERR, d); checks++;
    if (d !== 32'(k / period)) begin errors++; $display("FAIL abort_errcnt got=%0d required=%0d", d, k / period); end
    wb_read(A_FM, d); checks++;
    if (d !== ((k / period) > 0 ? 32'h1 : 32'h0)) begin errors++; $display("FAIL abort_failmask got=%h", d); end
    // START together with ABORT while idle must not launch a run
    b0 = busy_total;
    wb_write(A_CTRL, 32'h3);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy_total != b0) begin errors++; $display("FAIL abort_wins busy_cycles=%0d required=0", busy_total - b0); end
  endtask

  task automatic test_busy_writes();
    longint b0;
    logic [31:0] d;
    set_loopback_t1();
    program_all(2, 1);
    b0 = busy_total;
    wb_write(A_CTRL, 32'h1);
    wb_write(BASE + 32'h40, {16'h0, ~tt_m[0]});
    wb_write(A_SET, 32'h9);
    wb_write(A_CTRL, 32'h1);
    wb_read(BASE + 32'hFC, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL busy_fc got=%h required=0", d); end
    wait_done_and_check(b0, "busy_writes");
    wb_read(BASE + 32'h40, d); checks++;
    if (d !== {16'h0, tt_m[0]}) begin errors++; $display("FAIL busy_tt0 got=%h required=%h", d, tt_m[0]); end
    wb_read(A_SET, d); checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL busy_settle got=%h required=2", d); end
  endtask

  task automatic test_reset_mid();
    longint b0, k;
    int period, guard;
    logic [NUM_CH*MAX_IN-1:0] exp_in;
    logic [31:0] d;
    set_loopback_t1();
    program_all(8, 1);
    period = 2 + XTRA + 8;
    b0 = busy_total;
    wb_write(A_CTRL, 32'h1);
    guard = 0;
    while (!busy_o && guard < 10) begin @(posedge clk); #1; guard++; end
    checks++;
    if (!busy_o) begin errors++; $display("FAIL rstmid_busy got=0 required=1"); end
    repeat (24) @(posedge clk);
    #1;
    k = busy_total - b0;
    if ((k % period) != 0) begin
      for (int c = 0; c < NUM_CH; c++) exp_in[c*MAX_IN +: MAX_IN] = 4'(k / period);
      checks++;
      if (cut_in !== exp_in) begin errors++; $display("FAIL rstmid_cut_in got=%h required=%h", cut_in, exp_in); end
    end
    rst = 1'b1;
    #2;
    checks++;
    if ({wbs_ack_o, wbs_dat_o, cut_in, busy_o} !== '0) begin
      errors++; $display("FAIL rstmid_outputs ack=%b dat=%h cut_in=%h busy=%b required all 0", wbs_ack_o, wbs_dat_o, cut_in, busy_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wb_read(A_SET, d); checks++;
    if (d !== 32'd4) begin errors++; $display("FAIL rstmid_settle got=%h required=4", d); end
    wb_read(A_LOOP, d); checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL rstmid_loops got=%h required=1", d); end
    wb_read(A_STAT, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rstmid_status got=%h required=0", d); end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_dat_i = 32'h0; wbs_adr_i = 32'h0;
    for (int c = 0; c < NUM_CH; c++) begin cell_tt[c] = 16'h0; tt_m[c] = 16'h0; end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_regs();
    test_t1();
    test_t2();
    test_t3();
    test_random();
    test_abort();
    test_busy_writes();
    test_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
